// File: rtl/dlfloat_dot_seq.sv
// Byte-serial sequencer for the DLFloat16 MAC datapath: loads operand pairs,
// pulses the MAC per element, waits out its pipeline and returns the 16-bit result.
module dlfloat_dot_seq #(
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned MAC_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  output logic             mac_clr,
  output logic             mac_en,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  input  logic [15:0]      mac_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             done
);

  localparam int unsigned DCNT_W = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);

  typedef enum logic [3:0] {
    IDLE, LA0, LA1, LB0, LB1, ISSUE, DRAIN, OUT0, OUT1
  } state_t;

  state_t              state, state_nx;
  logic [LEN_W-1:0]    cnt, cnt_nx;
  logic [DCNT_W-1:0]   dcnt, dcnt_nx;
  logic [15:0]         res, res_nx;
  logic [15:0]         a_nx, b_nx;
  logic                clr_nx, done_nx;
  logic                busy_nx, in_ready_nx, mac_en_nx, out_valid_nx;
  logic [7:0]          out_byte_nx;
  logic                in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Next-state and next-output decode; outputs are registered from the next state.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dcnt_nx  = dcnt;
    res_nx   = res;
    a_nx     = mac_a;
    b_nx     = mac_b;
    clr_nx   = 1'b0;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          cnt_nx = vec_len;
          clr_nx = 1'b1;
          if (vec_len != LEN_W'(0)) begin
            state_nx = LA0;
          end else begin
            res_nx   = 16'h0000;
            state_nx = OUT0;
          end
        end
      end
      LA0: if (in_xfer) begin a_nx[7:0]  = in_byte; state_nx = LA1; end
      LA1: if (in_xfer) begin a_nx[15:8] = in_byte; state_nx = LB0; end
      LB0: if (in_xfer) begin b_nx[7:0]  = in_byte; state_nx = LB1; end
      LB1: if (in_xfer) begin b_nx[15:8] = in_byte; state_nx = ISSUE; end
      ISSUE: begin
        cnt_nx = cnt - LEN_W'(1);
        if (cnt == LEN_W'(1)) begin
          dcnt_nx  = DCNT_W'(MAC_LAT);
          state_nx = DRAIN;
        end else begin
          state_nx = LA0;
        end
      end
      DRAIN: begin
        dcnt_nx = dcnt - DCNT_W'(1);
        if (dcnt == DCNT_W'(1)) begin
          res_nx   = mac_acc;
          state_nx = OUT0;
        end
      end
      OUT0: if (out_xfer) state_nx = OUT1;
      OUT1: if (out_xfer) begin done_nx = 1'b1; state_nx = IDLE; end
      default: state_nx = IDLE;
    endcase

    busy_nx      = (state_nx != IDLE);
    in_ready_nx  = (state_nx == LA0) || (state_nx == LA1) ||
                   (state_nx == LB0) || (state_nx == LB1);
    mac_en_nx    = (state_nx == ISSUE);
    out_valid_nx = (state_nx == OUT0) || (state_nx == OUT1);
    out_byte_nx  = 8'h00;
    if (state_nx == OUT0) out_byte_nx = res_nx[7:0];
    if (state_nx == OUT1) out_byte_nx = res_nx[15:8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dcnt      <= '0;
      res       <= '0;
      mac_a     <= '0;
      mac_b     <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      out_valid <= 1'b0;
      out_byte  <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      dcnt      <= dcnt_nx;
      res       <= res_nx;
      mac_a     <= a_nx;
      mac_b     <= b_nx;
      busy      <= busy_nx;
      in_ready  <= in_ready_nx;
      mac_clr   <= clr_nx;
      mac_en    <= mac_en_nx;
      out_valid <= out_valid_nx;
      out_byte  <= out_byte_nx;
      done      <= done_nx;
    end
  end

endmodule

// File: tb/tb_dlfloat_dot_seq.sv
// Scoreboard bench for dlfloat_dot_seq with a two-stage integer MAC stand-in.
module tb_dlfloat_dot_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  vec_len = 8'd0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_byte = 8'h00;
  logic        mac_clr, mac_en;
  logic [15:0] mac_a, mac_b;
  logic [15:0] mac_acc;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_byte;
  logic        done;

  int total = 0;
  int bad   = 0;
  int n_en = 0, n_clr = 0, n_done = 0;
  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_ops[$];

  always #5 clk = ~clk;

  dlfloat_dot_seq #(.LEN_W(8), .MAC_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .mac_acc(mac_acc), .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .done(done)
  );

  // MAC stand-in: 1.0 (0x3E00) times x gives x, otherwise a^b; integer accumulate.
  logic [15:0] p_r;
  logic        p_v;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r <= '0; p_v <= 1'b0; mac_acc <= '0;
    end else begin
      p_v <= mac_en;
      if (mac_en)
        p_r <= (mac_a == 16'h3E00) ? mac_b : (mac_b == 16'h3E00) ? mac_a : (mac_a ^ mac_b);
      if (mac_clr)  mac_acc <= '0;
      else if (p_v) mac_acc <= mac_acc + p_r;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations on each output handshake and each mac_en pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_bytes.size() == 0) begin
          total++; bad++;
          $display("FAIL out_unexpected: got %h expected none", out_byte);
        end else chk("out_byte", 32'(out_byte), 32'(exp_bytes.pop_front()));
      end
      if (!out_valid) chk("out_byte_idle", 32'(out_byte), 32'h0);
      if (mac_en) begin
        n_en++;
        chk("in_ready_issue", 32'(in_ready), 32'h0);
        if (exp_ops.size() == 0) begin
          total++; bad++;
          $display("FAIL mac_en_unexpected: got %h%h expected none", mac_a, mac_b);
        end else chk("mac_ops", {mac_a, mac_b}, exp_ops.pop_front());
      end
      if (mac_clr) n_clr++;
      if (done)    n_done++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    t = 0;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk("in_ready_timeout", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_elem(input logic [15:0] a, input logic [15:0] b, input bit rnd);
    exp_ops.push_back({a, b});
    send_byte(a[7:0],  rnd ? int'($urandom_range(0, 3)) : 0);
    send_byte(a[15:8], rnd ? int'($urandom_range(0, 3)) : 0);
    send_byte(b[7:0],  rnd ? int'($urandom_range(0, 3)) : 0);
    send_byte(b[15:8], rnd ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic do_start(input logic [7:0] n);
    @(negedge clk);
    start   = 1'b1;
    vec_len = n;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) chk("idle_timeout", 32'(busy), 32'h0);
  endtask

  task automatic mid_reset(input string tag);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk({tag, "_busy"},     32'(busy),      32'h0);
    chk({tag, "_in_ready"}, 32'(in_ready),  32'h0);
    chk({tag, "_mac_en"},   32'(mac_en),    32'h0);
    chk({tag, "_mac_clr"},  32'(mac_clr),   32'h0);
    chk({tag, "_out_v"},    32'(out_valid), 32'h0);
    chk({tag, "_done"},     32'(done),      32'h0);
    chk({tag, "_mac_ab"},   {mac_a, mac_b}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("por_busy", 32'(busy), 32'h0);
    chk("por_out",  {23'h0, out_valid, out_byte}, 32'h0);
    rst_n = 1'b1;

    // Reset mid-load (after a_lo, a_hi)
    do_start(8'd2);
    send_byte(8'h00, 0);
    send_byte(8'h3E, 0);
    mid_reset("rst1");

    // N=1: 1.0 * 2.0 -> 0x4000
    exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h40);
    do_start(8'd1);
    send_elem(16'h3E00, 16'h4000, 1'b0);
    wait_idle();

    // N=3 with random gaps: 4200 + 4100 + (0012^0034=0026) = 8326
    exp_bytes.push_back(8'h26); exp_bytes.push_back(8'h83);
    do_start(8'd3);
    send_elem(16'h3E00, 16'h4200, 1'b1);
    send_elem(16'h4100, 16'h3E00, 1'b1);
    send_elem(16'h0012, 16'h0034, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("in_ready_drain", {31'h0, in_ready}, 32'h0);
      chk("busy_drain",     {31'h0, busy},     32'h1);
    end
    wait_idle();

    // Result stall in OUT0: 3E00*3E00 -> 0x3E00
    @(posedge clk); #1 out_ready = 1'b0;
    exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h3E);
    do_start(8'd1);
    send_elem(16'h3E00, 16'h3E00, 1'b0);
    begin
      int t = 0;
      @(negedge clk);
      while (!out_valid && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) chk("stall_timeout", 32'(out_valid), 32'h1);
    end
    repeat (5) begin
      chk("stall_hold", {22'h0, out_valid, done, out_byte}, {22'h0, 1'b1, 1'b0, 8'h00});
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle();

    // start while busy is ignored; 0002^0003 = 0001
    exp_bytes.push_back(8'h01); exp_bytes.push_back(8'h00);
    do_start(8'd1);
    exp_ops.push_back({16'h0002, 16'h0003});
    send_byte(8'h02, 0);
    do_start(8'd5);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    wait_idle();

    // vec_len = 0: clear pulse, no MAC issue, zero result
    exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h00);
    do_start(8'd0);
    wait_idle();

    // Reset during LB1, then inf operand passes unmodified
    do_start(8'd2);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    mid_reset("rst2");
    exp_bytes.push_back(8'hFF); exp_bytes.push_back(8'hFF);
    do_start(8'd1);
    send_elem(16'hFFFF, 16'h3E00, 1'b0);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("mac_en_count",  32'(n_en),   32'd7);
    chk("done_count",    32'(n_done), 32'd6);
    chk("mac_clr_count", 32'(n_clr),  32'd8);
    chk("bytes_left",    32'(exp_bytes.size()), 32'd0);
    chk("ops_left",      32'(exp_ops.size()),   32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
